tpu_seq_ctrl: RTL and testbench
===============================

# tpu_seq_ctrl

APB-programmable sequencer for the 2x2 systolic MAC array. It holds the four weight registers that drive the MAC tiles. It also runs a tile-count FSM that pops the two input FIFOs, then steers the array's two result columns into the result FIFO. This block replaces free-running `start`/counter sequencing: software writes weights and a tile count, sets START, and waits for DONE or IRQ.

## Interface
- RES_DEPTH, 16: result FIFO depth in words; used for the free-space check.
- LVL_W, 5: width of the FIFO level inputs.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  reset, asynchronous, active-low.
- i_psel, i_penable, i_pwrite  in  1 each  APB control.
- i_paddr  in  8  APB byte address.
- i_pwdata  in  32  APB write data.
- o_prdata  out  32  APB read data.
- o_pready  out  1  tied 1; no wait states.
- o_w00, o_w01, o_w10, o_w11  out  32 each  weights to the MAC tiles.
- i_in_lvl0, i_in_lvl1  in  LVL_W  word counts of input FIFO 0 and input FIFO 1.
- i_res_lvl  in  LVL_W  word count of the result FIFO.
- o_in_rd  out  1  pop strobe to both input FIFOs.
- o_res_wr  out  1  push strobe to the result FIFO.
- o_res_sel  out  1  result mux select: 0 = column-0 output, 1 = column-1 output.
- o_busy  out  1  FSM not in IDLE.
- o_irq  out  1  STATUS.DONE & CTRL.IRQ_EN.

## Operation
- Register map (word access):
  - 0x00 CTRL, RW:
    - bit0 START: write-1 pulse; always reads 0.
    - bit1 IRQ_EN.
    - bit2 ABORT: write-1 pulse; always reads 0.
    - [15:8] NUM_TILES.
  - 0x04 W00, 0x08 W01, 0x0C W10, 0x10 W11: RW weights.
  - 0x14 STATUS:
    - bit0 BUSY: RO.
    - bit1 DONE: write-1-to-clear.
    - bit2 ERR: write-1-to-clear.
  - 0x18 TILE_CNT: RO, [7:0] tiles completed in the current or last run.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus access:
  - A write takes effect on the edge where psel & penable & pwrite are all high.
  - o_prdata is combinational; it is valid when psel & !pwrite, and 0 otherwise.
- FSM states: IDLE, WAIT, FEED0, FEED1, DRN0, DRN1, DRN2, DRN3.
  - IDLE: START with NUM_TILES != 0 → WAIT. Same write clears TILE_CNT and DONE.
  - IDLE: START with NUM_TILES == 0 → stay IDLE and set ERR.
  - WAIT: move to FEED0 when i_in_lvl0 >= 2, i_in_lvl1 >= 2, and RES_DEPTH - i_res_lvl >= 4. Otherwise remain in WAIT indefinitely.
  - FEED0 → FEED1: o_in_rd = 1 in both states.
  - DRN0..DRN3: o_res_wr = 1 with o_res_sel = 0, 1, 0, 1 respectively.
  - DRN3 → TILE_CNT+1. If the new count equals NUM_TILES: go to IDLE and set DONE. Otherwise go to WAIT.
- Outputs are Moore, decoded from the state only.
- Error and override cases:
  - Weight or CTRL write while BUSY: the data is ignored and ERR is set. An ABORT bit in that write is still honoured.
  - START while BUSY: ignored and ERR is set.
  - ABORT in any state: FSM goes to IDLE on the next edge. DONE is not set and TILE_CNT is kept. Partially written results stay in the FIFO; software flushes them.
  - ABORT and START in the same write: ABORT wins and no run starts.
- Software clearing STATUS on the same edge that hardware sets DONE: the set wins.
- TILE_CNT is 8 bits; because NUM_TILES <= 255 it cannot wrap.

## Timing
- Reset values:
  - State IDLE.
  - All registers 0, including weights, CTRL, STATUS and TILE_CNT.
  - o_in_rd, o_res_wr, o_res_sel, o_busy and o_irq all 0.
  - o_prdata 0.
- START accepted at edge E0 → WAIT after E0. With resources ready, FEED0 after E1.
- Pop and push windows:
  - o_in_rd is high for exactly the 2 cycles after E1 and E2.
  - o_res_wr is high for the 4 cycles after E3–E6.
- Tile period is 7 cycles when resources are always available (WAIT + 2 FEED + 4 DRN).
- DONE, o_irq and !o_busy are all visible in the cycle after the DRN3 edge of the last tile.
- The result-FIFO space check happens only in WAIT, so DRN writes never stall and never overflow.
- Asynchronous reset mid-run: everything returns to reset values immediately. No strobe may glitch high after reset asserts.

## Test plan
- Reset then read all registers → every register reads 0, o_busy = 0, o_irq = 0.
- Write W00..W11 = 1, 2, 3, 4, then CTRL = 0x0103 with both FIFOs at level 2 and the result FIFO empty:
  - o_in_rd high for 2 cycles.
  - o_res_wr high for 4 cycles with sel 0, 1, 0, 1.
  - DONE = 1, TILE_CNT = 1, o_irq = 1.
- NUM_TILES = 3 with all FIFO levels ample:
  - 3 × 7-cycle tiles back to back.
  - 6 pops and 12 pushes total.
  - TILE_CNT = 3.
- Input FIFO 1 held at level 1 for 10 cycles, then raised to 2:
  - FSM stays in WAIT with no strobes.
  - FEED0 begins 1 cycle after the level reaches 2.
- Result FIFO at level 13 (RES_DEPTH 16) → WAIT holds. Drop the level to 12 → tile proceeds.
- Error and abort cases:
  - Write W01 during DRN1 → ERR = 1 and W01 unchanged.
  - ABORT during FEED1 → IDLE next cycle, DONE = 0, TILE_CNT unchanged.
  - START with NUM_TILES = 0 → ERR = 1 and o_busy stays 0.

Source files
------------

// File: rtl/tpu_seq_ctrl.sv
// tpu_seq_ctrl: APB register block and tile sequencer for the 2x2 systolic MAC array.
// Holds the four tile weights. For each tile it pops both input FIFOs for two cycles,
// then pushes four result words alternating between column 0 and column 1.
module tpu_seq_ctrl #(
    parameter int unsigned RES_DEPTH = 16,
    parameter int unsigned LVL_W     = 5
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_psel,
    input  logic             i_penable,
    input  logic             i_pwrite,
    input  logic [7:0]       i_paddr,
    input  logic [31:0]      i_pwdata,
    output logic [31:0]      o_prdata,
    output logic             o_pready,
    output logic [31:0]      o_w00,
    output logic [31:0]      o_w01,
    output logic [31:0]      o_w10,
    output logic [31:0]      o_w11,
    input  logic [LVL_W-1:0] i_in_lvl0,
    input  logic [LVL_W-1:0] i_in_lvl1,
    input  logic [LVL_W-1:0] i_res_lvl,
    output logic             o_in_rd,
    output logic             o_res_wr,
    output logic             o_res_sel,
    output logic             o_busy,
    output logic             o_irq
);

    localparam logic [7:0] A_CTRL   = 8'h00;
    localparam logic [7:0] A_W00    = 8'h04;
    localparam logic [7:0] A_W01    = 8'h08;
    localparam logic [7:0] A_W10    = 8'h0C;
    localparam logic [7:0] A_W11    = 8'h10;
    localparam logic [7:0] A_STATUS = 8'h14;
    localparam logic [7:0] A_TCNT   = 8'h18;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_FEED0 = 3'd2,
        S_FEED1 = 3'd3,
        S_DRN0  = 3'd4,
        S_DRN1  = 3'd5,
        S_DRN2  = 3'd6,
        S_DRN3  = 3'd7
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] w00_q, w01_q, w10_q, w11_q;
    logic        irq_en_q;
    logic [7:0]  num_tiles_q;
    logic        done_q, err_q;
    logic [7:0]  tile_cnt_q;
    logic [31:0] rdata;

    logic        wr_en, busy, ctrl_wr, wgt_wr, stat_wr;
    logic        abort_req, start_req, start_ok, start_zero, err_set;
    logic        tile_end, last_tile, done_set;
    logic [7:0]  tile_inc;
    logic [LVL_W:0] res_need;
    logic        res_ok, in_ok;

    assign wr_en   = i_psel & i_penable & i_pwrite;
    assign busy    = (state_q != S_IDLE);
    assign ctrl_wr = wr_en & (i_paddr == A_CTRL);
    assign wgt_wr  = wr_en & ((i_paddr == A_W00) | (i_paddr == A_W01) |
                              (i_paddr == A_W10) | (i_paddr == A_W11));
    assign stat_wr = wr_en & (i_paddr == A_STATUS);

    // ABORT overrides START in the same write; START is only considered when idle
    assign abort_req  = ctrl_wr & i_pwdata[2];
    assign start_req  = ctrl_wr & i_pwdata[0] & ~i_pwdata[2] & ~busy;
    assign start_ok   = start_req & (i_pwdata[15:8] != 8'd0);
    assign start_zero = start_req & (i_pwdata[15:8] == 8'd0);
    assign err_set    = ((ctrl_wr | wgt_wr) & busy) | start_zero;

    assign tile_inc  = tile_cnt_q + 8'd1;
    assign last_tile = (tile_inc == num_tiles_q);
    assign tile_end  = (state_q == S_DRN3) & ~abort_req;
    assign done_set  = tile_end & last_tile;

    // Result space is checked once per tile so the four drain pushes never stall
    assign res_need = {1'b0, i_res_lvl} + (LVL_W+1)'(4);
    assign res_ok   = (res_need <= (LVL_W+1)'(RES_DEPTH));
    assign in_ok    = (i_in_lvl0 >= LVL_W'(2)) && (i_in_lvl1 >= LVL_W'(2));

    // Sequencer state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and Moore strobe outputs
    always_comb begin
        state_d   = state_q;
        o_in_rd   = 1'b0;
        o_res_wr  = 1'b0;
        o_res_sel = 1'b0;
        o_busy    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_WAIT;
            S_WAIT:  if (in_ok && res_ok) state_d = S_FEED0;
            S_FEED0: begin o_in_rd = 1'b1; state_d = S_FEED1; end
            S_FEED1: begin o_in_rd = 1'b1; state_d = S_DRN0; end
            S_DRN0:  begin o_res_wr = 1'b1; state_d = S_DRN1; end
            S_DRN1:  begin o_res_wr = 1'b1; o_res_sel = 1'b1; state_d = S_DRN2; end
            S_DRN2:  begin o_res_wr = 1'b1; state_d = S_DRN3; end
            S_DRN3:  begin
                o_res_wr  = 1'b1;
                o_res_sel = 1'b1;
                state_d   = last_tile ? S_IDLE : S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
        if (abort_req) state_d = S_IDLE;
    end

    // Software-visible registers; hardware sets of DONE/ERR take priority over clears
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            w00_q       <= '0;
            w01_q       <= '0;
            w10_q       <= '0;
            w11_q       <= '0;
            irq_en_q    <= 1'b0;
            num_tiles_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            tile_cnt_q  <= '0;
        end else begin
            if (wr_en && !busy) begin
                case (i_paddr)
                    A_CTRL: begin
                        irq_en_q    <= i_pwdata[1];
                        num_tiles_q <= i_pwdata[15:8];
                    end
                    A_W00:   w00_q <= i_pwdata;
                    A_W01:   w01_q <= i_pwdata;
                    A_W10:   w10_q <= i_pwdata;
                    A_W11:   w11_q <= i_pwdata;
                    default: ;
                endcase
            end
            if (start_ok) begin
                tile_cnt_q <= '0;
            end else if (tile_end) begin
                tile_cnt_q <= tile_inc;
            end
            if (done_set) begin
                done_q <= 1'b1;
            end else if (start_ok || (stat_wr && i_pwdata[1])) begin
                done_q <= 1'b0;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (stat_wr && i_pwdata[2]) begin
                err_q <= 1'b0;
            end
        end
    end

    // Read-data mux
    always_comb begin
        rdata = '0;
        case (i_paddr)
            A_CTRL:   rdata = {16'd0, num_tiles_q, 6'd0, irq_en_q, 1'b0};
            A_W00:    rdata = w00_q;
            A_W01:    rdata = w01_q;
            A_W10:    rdata = w10_q;
            A_W11:    rdata = w11_q;
            A_STATUS: rdata = {29'd0, err_q, done_q, busy};
            A_TCNT:   rdata = {24'd0, tile_cnt_q};
            default:  rdata = '0;
        endcase
    end

    assign o_prdata = (i_psel & ~i_pwrite) ? rdata : '0;
    assign o_pready = 1'b1;
    assign o_w00    = w00_q;
    assign o_w01    = w01_q;
    assign o_w10    = w10_q;
    assign o_w11    = w11_q;
    assign o_irq    = done_q & irq_en_q;

endmodule

// File: tb/tb_tpu_seq_ctrl.sv
// Directed bench for tpu_seq_ctrl: table of register accesses plus timed tile sequences.
module tb_tpu_seq_ctrl;

    localparam int unsigned RES_DEPTH = 16;
    localparam int unsigned LVL_W     = 5;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [7:0]       paddr = '0;
    logic [31:0]      pwdata = '0;
    logic [31:0]      prdata;
    logic             pready;
    logic [31:0]      w00, w01, w10, w11;
    logic [LVL_W-1:0] lvl0 = '0, lvl1 = '0, rlvl = '0;
    logic             in_rd, res_wr, res_sel, busy, irq;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];

    tpu_seq_ctrl #(.RES_DEPTH(RES_DEPTH), .LVL_W(LVL_W)) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
        .i_paddr(paddr), .i_pwdata(pwdata),
        .o_prdata(prdata), .o_pready(pready),
        .o_w00(w00), .o_w01(w01), .o_w10(w10), .o_w11(w11),
        .i_in_lvl0(lvl0), .i_in_lvl1(lvl1), .i_res_lvl(rlvl),
        .o_in_rd(in_rd), .o_res_wr(res_wr), .o_res_sel(res_sel),
        .o_busy(busy), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
        psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
        psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
        #1;
        d = prdata;
        psel = 1'b0;
    endtask

    task automatic check_reg(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        apb_read(a, d);
        check(name, d, exp);
    endtask

    task automatic add_vec(input bit wr, input logic [7:0] a, input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.wr = wr; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic wait_idle(input int unsigned max, input string name);
        int unsigned k = 0;
        while (busy && k < max) begin
            tick();
            k++;
        end
        check(name, {31'd0, busy}, 32'd0);
    endtask

    // Samples strobes from the current cycle onwards, one bit per cycle
    task automatic trace(input int unsigned n, output logic [31:0] t_rd, output logic [31:0] t_wr,
                         output logic [31:0] t_sel, output logic [31:0] t_busy);
        t_rd = '0; t_wr = '0; t_sel = '0; t_busy = '0;
        for (int unsigned i = 0; i < n; i++) begin
            if (i > 0) tick();
            t_rd[i] = in_rd; t_wr[i] = res_wr; t_sel[i] = res_sel; t_busy[i] = busy;
        end
    endtask

    // Reference pattern: WAIT, FEED0, FEED1, DRN0..DRN3 per tile, idle afterwards
    task automatic exp_trace(input int unsigned tiles, output logic [31:0] e_rd, output logic [31:0] e_wr,
                             output logic [31:0] e_sel, output logic [31:0] e_busy);
        int unsigned ph;
        e_rd = '0; e_wr = '0; e_sel = '0; e_busy = '0;
        for (int unsigned i = 0; i < 7 * tiles; i++) begin
            ph = i % 7;
            e_rd[i]   = (ph == 1) || (ph == 2);
            e_wr[i]   = (ph >= 3);
            e_sel[i]  = (ph == 4) || (ph == 6);
            e_busy[i] = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t_rd, t_wr, t_sel, t_busy;
        logic [31:0] e_rd, e_wr, e_sel, e_busy;
        logic [31:0] d;
        int unsigned bad;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_strobes", {27'd0, in_rd, res_wr, res_sel, busy, irq}, 32'd0);
        check("rst_prdata", prdata, 32'd0);
        check("rst_w00", w00, 32'd0);
        rstn = 1'b1;
        tick();

        // Register table, sequencer idle (input FIFOs empty)
        add_vec(0, 8'h00, 0, 32'h0); add_vec(0, 8'h04, 0, 32'h0); add_vec(0, 8'h08, 0, 32'h0);
        add_vec(0, 8'h0C, 0, 32'h0); add_vec(0, 8'h10, 0, 32'h0); add_vec(0, 8'h14, 0, 32'h0);
        add_vec(0, 8'h18, 0, 32'h0); add_vec(0, 8'h1C, 0, 32'h0);
        add_vec(1, 8'h04, 32'd1, 0); add_vec(1, 8'h08, 32'd2, 0);
        add_vec(1, 8'h0C, 32'd3, 0); add_vec(1, 8'h10, 32'd4, 0);
        add_vec(1, 8'h1C, 32'hFFFF_FFFF, 0); add_vec(1, 8'h18, 32'h0000_00FF, 0);
        add_vec(0, 8'h04, 0, 32'd1); add_vec(0, 8'h08, 0, 32'd2);
        add_vec(0, 8'h0C, 0, 32'd3); add_vec(0, 8'h10, 0, 32'd4);
        add_vec(0, 8'h1C, 0, 32'h0); add_vec(0, 8'h18, 0, 32'h0);
        add_vec(1, 8'h00, 32'h0000_0502, 0); add_vec(0, 8'h00, 0, 32'h0000_0502);
        add_vec(1, 8'h00, 32'h0000_0001, 0); add_vec(0, 8'h00, 0, 32'h0);
        add_vec(0, 8'h14, 0, 32'h4);
        add_vec(1, 8'h14, 32'h4, 0); add_vec(0, 8'h14, 0, 32'h0);
        add_vec(1, 8'h00, 32'h0000_FF06, 0); add_vec(0, 8'h00, 0, 32'h0000_FF02);
        add_vec(0, 8'h14, 0, 32'h0);
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data);
            end else begin
                apb_read(vecs[i].addr, d);
                check($sformatf("vec%0d_rd_%02h", i, vecs[i].addr), d, vecs[i].exp);
            end
        end
        check("tbl_busy", {31'd0, busy}, 32'd0);
        check("tbl_weights", {w00[7:0], w01[7:0], w10[7:0], w11[7:0]}, 32'h0102_0304);
        psel = 1'b1; pwrite = 1'b1; paddr = 8'h04; #1;
        check("prdata_on_write", prdata, 32'd0);
        psel = 1'b0; pwrite = 1'b0;
        tick();

        // Single tile, exact strobe timing
        lvl0 = 5'd2; lvl1 = 5'd2; rlvl = 5'd0;
        apb_write(8'h00, 32'h0000_0103);
        trace(8, t_rd, t_wr, t_sel, t_busy);
        exp_trace(1, e_rd, e_wr, e_sel, e_busy);
        check("t1_in_rd", t_rd, e_rd);
        check("t1_res_wr", t_wr, e_wr);
        check("t1_res_sel", t_sel, e_sel);
        check("t1_busy", t_busy, e_busy);
        check("t1_irq", {31'd0, irq}, 32'd1);
        check_reg("t1_status", 8'h14, 32'h2);
        check_reg("t1_tile_cnt", 8'h18, 32'd1);

        // Three tiles back to back
        lvl0 = 5'd8; lvl1 = 5'd8;
        apb_write(8'h00, 32'h0000_0303);
        check("t3_done_cleared", {31'd0, irq}, 32'd0);
        trace(22, t_rd, t_wr, t_sel, t_busy);
        exp_trace(3, e_rd, e_wr, e_sel, e_busy);
        check("t3_in_rd", t_rd, e_rd);
        check("t3_res_wr", t_wr, e_wr);
        check("t3_res_sel", t_sel, e_sel);
        check("t3_busy", t_busy, e_busy);
        check("t3_pops", $countones(t_rd), 32'd6);
        check("t3_pushes", $countones(t_wr), 32'd12);
        check_reg("t3_tile_cnt", 8'h18, 32'd3);
        check_reg("t3_status", 8'h14, 32'h2);

        // Input FIFO 1 short by one word
        lvl0 = 5'd2; lvl1 = 5'd1;
        apb_write(8'h00, 32'h0000_0101);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (in_rd || res_wr || !busy) bad++;
        end
        check("lvl1_wait_hold", bad, 32'd0);
        lvl1 = 5'd2;
        check("lvl1_no_pop_yet", {31'd0, in_rd}, 32'd0);
        tick();
        check("lvl1_feed0", {31'd0, in_rd}, 32'd1);
        wait_idle(20, "lvl1_finish");
        check("lvl1_irq_off", {31'd0, irq}, 32'd0);
        check_reg("lvl1_status", 8'h14, 32'h2);

        // Result FIFO space boundary: 3 free words holds, 4 free proceeds
        rlvl = 5'd13;
        apb_write(8'h00, 32'h0000_0101);
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (in_rd || res_wr || !busy) bad++;
        end
        check("res13_hold", bad, 32'd0);
        rlvl = 5'd12;
        tick();
        check("res12_feed0", {31'd0, in_rd}, 32'd1);
        wait_idle(20, "res12_finish");
        rlvl = 5'd0;

        // Weight write landing in DRN1
        apb_write(8'h00, 32'h0000_0101);
        repeat (3) tick();
        check("drn0_sel", {30'd0, res_wr, res_sel}, 32'h2);
        apb_write(8'h08, 32'hDEAD_BEEF);
        check_reg("wbusy_status", 8'h14, 32'h5);
        wait_idle(20, "wbusy_finish");
        check_reg("wbusy_w01", 8'h08, 32'd2);
        check("wbusy_o_w01", w01, 32'd2);
        check_reg("wbusy_tile_cnt", 8'h18, 32'd1);
        apb_write(8'h14, 32'h6);
        check_reg("w1c_status", 8'h14, 32'h0);

        // ABORT during FEED1 of the second tile
        apb_write(8'h00, 32'h0000_0201);
        repeat (8) tick();
        check("abort_pre_feed0", {31'd0, in_rd}, 32'd1);
        check_reg("abort_pre_cnt", 8'h18, 32'd1);
        apb_write(8'h00, 32'h0000_0204);
        check("abort_idle", {29'd0, busy, in_rd, res_wr}, 32'd0);
        check_reg("abort_status", 8'h14, 32'h4);
        check_reg("abort_tile_cnt", 8'h18, 32'd1);
        check_reg("abort_ctrl", 8'h00, 32'h0000_0200);
        repeat (2) tick();
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
        apb_write(8'h14, 32'h4);
        apb_write(8'h00, 32'h0000_0105);
        check("abort_start_busy", {31'd0, busy}, 32'd0);
        tick();
        check("abort_start_busy2", {31'd0, busy}, 32'd0);
        check_reg("abort_start_status", 8'h14, 32'h0);

        // DONE clear on the same edge as DONE set: the set wins
        apb_write(8'h00, 32'h0000_0101);
        repeat (5) tick();
        apb_write(8'h14, 32'h2);
        check_reg("setwins_status", 8'h14, 32'h2);
        apb_write(8'h14, 32'h2);
        check_reg("clear_status", 8'h14, 32'h0);

        // Asynchronous reset in the middle of the drain
        apb_write(8'h00, 32'h0000_0103);
        repeat (3) tick();
        check("arst_pre_wr", {31'd0, res_wr}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("arst_strobes", {27'd0, in_rd, res_wr, res_sel, busy, irq}, 32'd0);
        check("arst_w00", w00, 32'd0);
        tick();
        check("arst_held", {31'd0, res_wr}, 32'd0);
        #3;
        rstn = 1'b1;
        tick();
        check("arst_after_busy", {31'd0, busy}, 32'd0);
        check_reg("arst_ctrl", 8'h00, 32'h0);
        check_reg("arst_tile_cnt", 8'h18, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
